// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared constants for the video dither path.
//   COLOR_W     : width of the raw colour channel coming from the palette stage
//   IDX_W       : width of the screen-position counters (4x4 Bayer tile)
//   BAYER_FLAT  : 4x4 ordered-dither matrix, element (yi*4+xi) at nibble yi*4+xi
//   bayer_at()  : lookup of one Bayer entry by row/column index
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int COLOR_W = 5;
    localparam int IDX_W   = 2;

    // Rows (yi = 0..3): {0,8,2,10} {12,4,14,6} {3,11,1,9} {15,7,13,5}.
    // Nibble 0 (LSB) is row 0 / column 0; nibble 15 (MSB) is row 3 / column 3.
    localparam logic [63:0] BAYER_FLAT = 64'h5D7F_91B3_6E4C_A280;

    // Returns B[yi][xi] as a 4-bit threshold level.
    function automatic logic [3:0] bayer_at(input logic [IDX_W-1:0] yi,
                                            input logic [IDX_W-1:0] xi);
        logic [3:0] idx;
        idx = {yi, xi};
        return BAYER_FLAT[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/video_dither_if.sv
// -----------------------------------------------------------------------------
// video_dither_if
// Pixel bus between the palette stage, the dither block and the DAC driver.
//   c3                        : pixel strobe
//   red_in/grn_in/blu_in      : raw COLOR_W-bit colour
//   blank_in/hsync_in/vsync_in: active-high controls aligned with the colour
//   red_out/grn_out/blu_out   : OUT_W-bit dithered colour
//   blank_out/hsync_out/vsync_out : delay-matched controls
// Modports:
//   master : pixel source (drives inputs, observes outputs)
//   slave  : dither block (consumes inputs, drives outputs)
// -----------------------------------------------------------------------------
interface video_dither_if #(
    parameter int OUT_W = 3
);
    import video_pkg::*;

    logic               c3;
    logic [COLOR_W-1:0] red_in;
    logic [COLOR_W-1:0] grn_in;
    logic [COLOR_W-1:0] blu_in;
    logic               blank_in;
    logic               hsync_in;
    logic               vsync_in;

    logic [OUT_W-1:0]   red_out;
    logic [OUT_W-1:0]   grn_out;
    logic [OUT_W-1:0]   blu_out;
    logic               blank_out;
    logic               hsync_out;
    logic               vsync_out;

    modport master (
        output c3, red_in, grn_in, blu_in, blank_in, hsync_in, vsync_in,
        input  red_out, grn_out, blu_out, blank_out, hsync_out, vsync_out
    );

    modport slave (
        input  c3, red_in, grn_in, blu_in, blank_in, hsync_in, vsync_in,
        output red_out, grn_out, blu_out, blank_out, hsync_out, vsync_out
    );

endinterface

// File: rtl/dither_chan.sv
// -----------------------------------------------------------------------------
// dither_chan
// One colour channel of the ordered ditherer (purely combinational; the
// caller registers the result).
//   i_color     : raw COLOR_W-bit channel value
//   i_thr       : threshold for this pixel position, COLOR_W-OUT_W bits
//   i_dither_en : 1 = ordered dither, 0 = plain truncation
//   o_out       : OUT_W-bit result
// The upper OUT_W bits are kept; the dropped low bits are compared with the
// threshold and, when larger, round the kept value up by one. The round-up is
// suppressed at full scale so white never wraps to black.
// -----------------------------------------------------------------------------
module dither_chan
    import video_pkg::*;
#(
    parameter int OUT_W = 3
) (
    input  logic [COLOR_W-1:0]       i_color,
    input  logic [COLOR_W-OUT_W-1:0] i_thr,
    input  logic                     i_dither_en,
    output logic [OUT_W-1:0]         o_out
);

    logic [OUT_W-1:0]         w_hi;
    logic [COLOR_W-OUT_W-1:0] w_lo;
    logic                     w_bump;

    // Split the channel, decide on the round-up and apply it without overflow.
    always_comb begin
        w_hi   = i_color[COLOR_W-1 -: OUT_W];
        w_lo   = i_color[COLOR_W-OUT_W-1:0];
        w_bump = i_dither_en && (w_lo > i_thr) && (w_hi != {OUT_W{1'b1}});
        if (w_bump) begin
            o_out = w_hi + OUT_W'(1'b1);
        end else begin
            o_out = w_hi;
        end
    end

endmodule

// File: rtl/video_dither.sv
// -----------------------------------------------------------------------------
// video_dither
// Reduces 5-bit RGB to OUT_W bits per channel with a 4x4 ordered (Bayer)
// dither, optionally rotated every frame. Two-strobe pipeline for colour and
// controls alike; all state advances only on the pixel strobe c3.
// Parameters:
//   OUT_W      : output bits per channel, legal 1..4
//   DITHER_DEF : dither_en value integrators assume; does not affect logic
// Ports:
//   clk         : video clock, all flops on posedge
//   rst_n       : asynchronous active-low reset
//   dither_en   : 1 = ordered dither, 0 = truncation
//   temporal_en : 1 = rotate the pattern by the frame counter
//   vif         : pixel bus (slave side), see video_dither_if
// -----------------------------------------------------------------------------
module video_dither
    import video_pkg::*;
#(
    parameter int OUT_W      = 3,
    parameter bit DITHER_DEF = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dither_en,
    input  logic          temporal_en,
    video_dither_if.slave vif
);

    localparam int THR_W = COLOR_W - OUT_W;

    // Position / frame tracking
    logic             r_hs_prev;
    logic             r_vs_prev;
    logic [IDX_W-1:0] r_x;
    logic [IDX_W-1:0] r_y;
    logic [IDX_W-1:0] r_frame;

    logic             w_hs_rise;
    logic             w_vs_rise;
    logic [IDX_W-1:0] w_x_nxt;
    logic [IDX_W-1:0] w_y_nxt;
    logic [IDX_W-1:0] w_frame_nxt;
    logic [IDX_W-1:0] w_xi;
    logic [IDX_W-1:0] w_yi;
    logic [3:0]       w_bayer;
    logic [THR_W-1:0] w_thr;

    // Stage 1: sampled pixel plus its threshold
    logic [COLOR_W-1:0] r_s1_red;
    logic [COLOR_W-1:0] r_s1_grn;
    logic [COLOR_W-1:0] r_s1_blu;
    logic               r_s1_blank;
    logic               r_s1_hs;
    logic               r_s1_vs;
    logic               r_s1_dith;
    logic [THR_W-1:0]   r_s1_thr;

    // Dithered colour computed from stage 1
    logic [OUT_W-1:0] w_red_d;
    logic [OUT_W-1:0] w_grn_d;
    logic [OUT_W-1:0] w_blu_d;

    // Stage 2: output registers
    logic [OUT_W-1:0] r_s2_red;
    logic [OUT_W-1:0] r_s2_grn;
    logic [OUT_W-1:0] r_s2_blu;
    logic             r_s2_blank;
    logic             r_s2_hs;
    logic             r_s2_vs;

    // DITHER_DEF is informational only; this keeps it referenced.
    logic w_unused;
    assign w_unused = &{1'b0, DITHER_DEF};

    // Sync edge detection, next counter values and threshold lookup.
    always_comb begin
        w_hs_rise = vif.hsync_in & ~r_hs_prev;
        w_vs_rise = vif.vsync_in & ~r_vs_prev;

        // x restarts on a new line, otherwise walks active pixels only.
        if (w_hs_rise) begin
            w_x_nxt = {IDX_W{1'b0}};
        end else if (!vif.blank_in) begin
            w_x_nxt = r_x + IDX_W'(1'b1);
        end else begin
            w_x_nxt = r_x;
        end

        // vsync wins over hsync so a coincident rise leaves y at 0.
        if (w_vs_rise) begin
            w_y_nxt = {IDX_W{1'b0}};
        end else if (w_hs_rise) begin
            w_y_nxt = r_y + IDX_W'(1'b1);
        end else begin
            w_y_nxt = r_y;
        end

        if (w_vs_rise) begin
            w_frame_nxt = r_frame + IDX_W'(1'b1);
        end else begin
            w_frame_nxt = r_frame;
        end

        // Temporal mode slides the tile diagonally by one step per frame.
        if (temporal_en) begin
            w_xi = r_x + r_frame;
            w_yi = r_y + r_frame;
        end else begin
            w_xi = r_x;
            w_yi = r_y;
        end

        // Keeping the top THR_W bits equals B >> (4 - THR_W).
        w_bayer = bayer_at(w_yi, w_xi);
        w_thr   = w_bayer[3 -: THR_W];
    end

    // Counter and sync-history registers, advanced on each pixel strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_x       <= {IDX_W{1'b0}};
            r_y       <= {IDX_W{1'b0}};
            r_frame   <= {IDX_W{1'b0}};
        end else if (vif.c3) begin
            r_hs_prev <= vif.hsync_in;
            r_vs_prev <= vif.vsync_in;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_frame   <= w_frame_nxt;
        end
    end

    // Stage 1: capture the pixel, its controls and its threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_red   <= {COLOR_W{1'b0}};
            r_s1_grn   <= {COLOR_W{1'b0}};
            r_s1_blu   <= {COLOR_W{1'b0}};
            r_s1_blank <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s1_dith  <= 1'b0;
            r_s1_thr   <= {THR_W{1'b0}};
        end else if (vif.c3) begin
            r_s1_red   <= vif.red_in;
            r_s1_grn   <= vif.grn_in;
            r_s1_blu   <= vif.blu_in;
            r_s1_blank <= vif.blank_in;
            r_s1_hs    <= vif.hsync_in;
            r_s1_vs    <= vif.vsync_in;
            // Mode travels with the pixel so a mid-stream change stays aligned.
            r_s1_dith  <= dither_en;
            r_s1_thr   <= w_thr;
        end
    end

    dither_chan #(.OUT_W(OUT_W)) u_chan_red (
        .i_color     (r_s1_red),
        .i_thr       (r_s1_thr),
        .i_dither_en (r_s1_dith),
        .o_out       (w_red_d)
    );

    dither_chan #(.OUT_W(OUT_W)) u_chan_grn (
        .i_color     (r_s1_grn),
        .i_thr       (r_s1_thr),
        .i_dither_en (r_s1_dith),
        .o_out       (w_grn_d)
    );

    dither_chan #(.OUT_W(OUT_W)) u_chan_blu (
        .i_color     (r_s1_blu),
        .i_thr       (r_s1_thr),
        .i_dither_en (r_s1_dith),
        .o_out       (w_blu_d)
    );

    // Stage 2: register the result; colour is forced black during blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_red   <= {OUT_W{1'b0}};
            r_s2_grn   <= {OUT_W{1'b0}};
            r_s2_blu   <= {OUT_W{1'b0}};
            r_s2_blank <= 1'b0;
            r_s2_hs    <= 1'b0;
            r_s2_vs    <= 1'b0;
        end else if (vif.c3) begin
            if (r_s1_blank) begin
                r_s2_red <= {OUT_W{1'b0}};
                r_s2_grn <= {OUT_W{1'b0}};
                r_s2_blu <= {OUT_W{1'b0}};
            end else begin
                r_s2_red <= w_red_d;
                r_s2_grn <= w_grn_d;
                r_s2_blu <= w_blu_d;
            end
            r_s2_blank <= r_s1_blank;
            r_s2_hs    <= r_s1_hs;
            r_s2_vs    <= r_s1_vs;
        end
    end

    assign vif.red_out   = r_s2_red;
    assign vif.grn_out   = r_s2_grn;
    assign vif.blu_out   = r_s2_blu;
    assign vif.blank_out = r_s2_blank;
    assign vif.hsync_out = r_s2_hs;
    assign vif.vsync_out = r_s2_vs;

endmodule

// File: tb/tb_video_dither.sv
// -----------------------------------------------------------------------------
// tb_video_dither
// Randomized, scoreboard-checked bench for video_dither (OUT_W = 3).
// The driver computes the expected output of every strobed pixel from a
// behavioural model and queues it; a monitor compares the DUT outputs after
// every clock edge (new value on a strobe, held value otherwise).
// -----------------------------------------------------------------------------
module tb_video_dither;

    localparam int OUT_W = 3;
    localparam int DROP  = 5 - OUT_W;

    typedef struct {
        int r;
        int g;
        int b;
        bit bl;
        bit hs;
        bit vs;
    } exp_t;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic dither_en   = 1'b0;
    logic temporal_en = 1'b0;

    video_dither_if #(.OUT_W(OUT_W)) vif ();

    video_dither #(.OUT_W(OUT_W), .DITHER_DEF(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dither_en   (dither_en),
        .temporal_en (temporal_en),
        .vif         (vif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];
    exp_t last;
    exp_t zero_e = '{r: 0, g: 0, b: 0, bl: 1'b0, hs: 1'b0, vs: 1'b0};

    // Behavioural model state: screen position, frame and sync history
    int m_x, m_y, m_frame;
    bit m_hsp, m_vsp;
    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Quantize one channel: keep the top bits, round up when the dropped
    // bits exceed the threshold, never past full scale.
    function automatic int quant(input int c, input int thr, input bit den);
        int hi, lo, maxv;
        hi   = c / (1 << DROP);
        lo   = c % (1 << DROP);
        maxv = (1 << OUT_W) - 1;
        if (den && lo > thr && hi != maxv) return hi + 1;
        return hi;
    endfunction

    // One strobed pixel; force_r >= 0 replaces the model red value with a
    // hand-derived constant.
    task automatic strobe(input int r, input int g, input int b,
                          input bit bl, input bit hs, input bit vs,
                          input bit den, input bit ten, input int force_r);
        exp_t e;
        int xi, yi, thr;
        bit hr, vr;
        @(negedge clk);
        vif.c3       = 1'b1;
        vif.red_in   = 5'(r);
        vif.grn_in   = 5'(g);
        vif.blu_in   = 5'(b);
        vif.blank_in = bl;
        vif.hsync_in = hs;
        vif.vsync_in = vs;
        dither_en    = den;
        temporal_en  = ten;
        xi  = ten ? (m_x + m_frame) % 4 : m_x;
        yi  = ten ? (m_y + m_frame) % 4 : m_y;
        thr = bayer[yi][xi] / (1 << (4 - DROP));
        e.r  = bl ? 0 : quant(r, thr, den);
        e.g  = bl ? 0 : quant(g, thr, den);
        e.b  = bl ? 0 : quant(b, thr, den);
        if (force_r >= 0) e.r = force_r;
        e.bl = bl;
        e.hs = hs;
        e.vs = vs;
        q.push_back(e);
        hr = hs && !m_hsp;
        vr = vs && !m_vsp;
        if (hr) m_x = 0;
        else if (!bl) m_x = (m_x + 1) % 4;
        if (vr) m_y = 0;
        else if (hr) m_y = (m_y + 1) % 4;
        if (vr) m_frame = (m_frame + 1) % 4;
        m_hsp = hs;
        m_vsp = vs;
    endtask

    // A clock with no strobe; inputs wander to show they are ignored.
    task automatic idle();
        @(negedge clk);
        vif.c3       = 1'b0;
        vif.red_in   = 5'($urandom);
        vif.grn_in   = 5'($urandom);
        vif.blu_in   = 5'($urandom);
        vif.blank_in = 1'($urandom);
        vif.hsync_in = 1'($urandom);
        vif.vsync_in = 1'($urandom);
        dither_en    = 1'($urandom);
        temporal_en  = 1'($urandom);
    endtask

    // Assert reset between clock edges and check the outputs clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        vif.c3 = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_red",   int'(vif.red_out),   0);
        chk("rst_grn",   int'(vif.grn_out),   0);
        chk("rst_blu",   int'(vif.blu_out),   0);
        chk("rst_blank", int'(vif.blank_out), 0);
        chk("rst_hsync", int'(vif.hsync_out), 0);
        chk("rst_vsync", int'(vif.vsync_out), 0);
        m_x = 0; m_y = 0; m_frame = 0; m_hsp = 1'b0; m_vsp = 1'b0;
        q.delete();
        // The first strobe after release shows the cleared stage 1.
        q.push_back(zero_e);
        last = zero_e;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pop on strobes, otherwise the previous value must hold.
    always @(posedge clk) begin : mon
        bit was_strobe;
        was_strobe = vif.c3;
        #1;
        if (rst_n) begin
            if (was_strobe && q.size() >= 2) last = q.pop_front();
            chk("red_out",   int'(vif.red_out),   last.r);
            chk("grn_out",   int'(vif.grn_out),   last.g);
            chk("blu_out",   int'(vif.blu_out),   last.b);
            chk("blank_out", int'(vif.blank_out), int'(last.bl));
            chk("hsync_out", int'(vif.hsync_out), int'(last.hs));
            chk("vsync_out", int'(vif.vsync_out), int'(last.vs));
        end
    end

    initial begin
        vif.c3 = 1'b0; vif.red_in = 5'd0; vif.grn_in = 5'd0; vif.blu_in = 5'd0;
        vif.blank_in = 1'b0; vif.hsync_in = 1'b0; vif.vsync_in = 1'b0;

        // Threshold examples with red = 00011: (0,0)->001, (0,3)->000, (3,3)->001
        do_reset();
        strobe(3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            strobe(9, 9, 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
            strobe(9, 9, 9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        end
        strobe(3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        strobe(3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        strobe(3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        strobe(3, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        // Truncation: 10111 -> 101
        do_reset();
        idle();
        strobe(23, 23, 23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);

        // Coincident sync rise gives frame 1 at (0,0); temporal index hits B[1][1]=4
        do_reset();
        strobe(31, 31, 31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        strobe(31, 31, 31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        strobe(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        strobe(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);

        // Full-scale white over every position, frame and rotation: never wraps
        for (int k = 0; k < 80; k++) begin
            bit hs, vs;
            hs = (k % 5 == 4);
            vs = (k % 23 == 22);
            strobe(31, 31, 31, 1'b0, hs, vs, 1'b1, 1'($urandom), 7);
        end

        // Blanking run of three strobes with bright colour
        for (int k = 0; k < 6; k++) begin
            strobe(21, 13, 27, (k >= 1 && k <= 3), 1'b0, 1'b0, 1'b1, 1'b0, -1);
        end

        // Random traffic with idle gaps and a mid-line reset
        for (int i = 0; i < 1500; i++) begin
            int gaps;
            if (i == 700) do_reset();
            gaps = $urandom_range(0, 2);
            for (int j = 0; j < gaps; j++) idle();
            strobe($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   ($urandom % 4 == 0), ($urandom % 6 == 0), ($urandom % 40 == 0),
                   ($urandom % 4 != 0), 1'($urandom), -1);
        end

        // Flush the last pixel through stage 2
        strobe(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle();
        idle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_dither.md
VIDEO_DITHER -- requirements
Module: video_dither

Interface
REQ-001 Parameter OUT_W, default 3: output bits per colour channel; legal range 1..4.
REQ-002 Parameter DITHER_DEF, default 1: dither_en value assumed by integrators; no effect on logic.
REQ-003 clk  in  1  system video clock; all flops on posedge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active low.
REQ-005 c3  in  1  pixel strobe; all state advances only when c3=1.
REQ-006 red_in / grn_in / blu_in  in  5 each  raw 5-bit colour from the palette/CRAM stage.
REQ-007 blank_in  in  1  active-high blanking, aligned with colour inputs.
REQ-008 hsync_in / vsync_in  in  1 each  active-high syncs, aligned with colour inputs.
REQ-009 dither_en  in  1  enables ordered dithering; 0 selects plain truncation.
REQ-010 temporal_en  in  1  enables per-frame rotation of the dither pattern.
REQ-011 red_out / grn_out / blu_out  out  OUT_W each  colour to resistor DAC.
REQ-012 blank_out / hsync_out / vsync_out  out  1 each  delay-matched control outputs.

Function
REQ-013 Latency: exactly 2 c3 strobes, input sample to output, for colour, blank and syncs alike.
REQ-014 With c3=0, every register holds its value.
REQ-015 Edge detect: hs_prev and vs_prev are registered on each c3; a rise is level=1 while prev=0.
REQ-016 x[1:0]: on an hsync rise, reset to 0; otherwise increment (wrapping 3->0) on each c3 with blank_in=0.
REQ-017 y[1:0]: on a vsync rise, reset to 0; otherwise increment (wrapping) on an hsync rise.
REQ-018 frame[1:0]: increment (wrapping) on a vsync rise.
REQ-019 Simultaneous hsync and vsync rise on one c3: x=0, y=0, frame incremented once.
REQ-020 Index: xi=x, yi=y when temporal_en=0; otherwise xi=x+frame and yi=y+frame, both mod 4.
REQ-021 Bayer B[yi][xi], rows yi=0..3: {0,8,2,10} {12,4,14,6} {3,11,1,9} {15,7,13,5}.
REQ-022 Per channel: D=5-OUT_W; hi=c[4:D]; lo=c[D-1:0]; thr=B>>(4-D).
REQ-023 dither_en=1: out=hi+1 when lo>thr and hi is not all-ones; otherwise out=hi.
REQ-024 dither_en=0: out=hi.
REQ-025 Stage 1 registers the threshold and the input colour/control. Stage 2 registers the result, forced to 0 when the stage-1 blank=1.
REQ-026 Output never wraps: all-ones input yields all-ones output at every position.

Reset
REQ-027 rst_n=0 asynchronously clears all outputs, both pipeline stages, x, y, frame, hs_prev and vs_prev to 0.
REQ-028 Reset mid-line or mid-frame: after release, counting resumes from 0; no partial-state recovery.
REQ-029 First valid output appears on the 2nd c3 after release.

Structure
REQ-030 Shared package video_pkg holds the Bayer matrix constant and the 5-bit raw-colour width.
REQ-031 Sub-module dither_chan (hi/lo split, threshold compare, saturating increment) is instantiated 3 times, once per channel.
REQ-032 video_dither holds only counters, edge detect, index and pipeline registers; target 120-250 lines total.

Verification
REQ-033 dither_en=0, red_in=5'b10111, OUT_W=3: red_out=3'b101 after exactly 2 c3 strobes.
REQ-034 dither_en=1, temporal_en=0, red_in=5'b00011 (lo=3), OUT_W=3:
  - x=0, y=0 (thr 0): red_out=001
  - x=3, y=3 (thr 1): red_out=001
  - x=0, y=3 (thr 3): red_out=000
REQ-035 red_in=grn_in=blu_in=5'b11111 with dither_en=1, all 16 positions: outputs stay 111; no wrap to 000.
REQ-036 blank_in=1 for 3 c3 strobes with nonzero colour:
  - outputs are 0 for exactly 3 strobes, 2 strobes later
  - x does not advance during blank
REQ-037 Counters, temporal rotation and reset:
  - 4 hsync pulses: y goes 1,2,3,0.
  - hsync and vsync rising together: x=0, y=0, frame +1.
  - temporal_en=1, frame=1: the pixel at x=0, y=0 uses B[1][1]=4.
  - rst_n pulsed mid-line clears all outputs immediately, without waiting for clk.
